// File: rtl/id_stage_reg_if.sv
// IF->ID stage bus: fetch-side handshake, flush, and the ID-side outputs.
// The stage itself connects through the slave modport; the fetch/decode
// environment connects through the master modport.
interface id_stage_reg_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NTYPE = 5
);
   logic              if_valid;
   logic              if_ready;
   logic [31:0]       if_instr;
   logic [XLEN-1:0]   if_pc;
   logic              flush;
   logic              id_ready;
   logic              id_valid;
   logic [31:0]       id_instr;
   logic [XLEN-1:0]   id_pc;
   logic [NTYPE-1:0]  id_instr_type;
   logic              id_illegal;

   modport slave (
      input  if_valid, if_instr, if_pc, flush, id_ready,
      output if_ready, id_valid, id_instr, id_pc, id_instr_type, id_illegal
   );

   modport master (
      output if_valid, if_instr, if_pc, flush, id_ready,
      input  if_ready, id_valid, id_instr, id_pc, id_instr_type, id_illegal
   );
endinterface

// File: rtl/id_stage_reg.sv
// IF->ID pipeline register with a 2-entry skid buffer and one-hot opcode
// type decode (bit order B,I,J,S,U = 0..4; all-zero for R-type/unknown).
// if_ready is registered, so no combinational path reaches fetch.
// Optional feature macro: ILL_INSTR_CHECK_EN (registers id_illegal for
// unrecognised opcodes; when undefined id_illegal is tied 0).
module id_stage_reg #(
   parameter int unsigned     XLEN        = 32,
   parameter logic [31:0]     RESET_INSTR = 32'h0000_0013,
   parameter logic [XLEN-1:0] RESET_PC    = '0
) (
   input logic           clk,
   input logic           rst,
   id_stage_reg_if.slave bus
);
   localparam int unsigned NTYPE   = 5;
   localparam int unsigned B_INDEX = 0;
   localparam int unsigned I_INDEX = 1;
   localparam int unsigned J_INDEX = 2;
   localparam int unsigned S_INDEX = 3;
   localparam int unsigned U_INDEX = 4;

   function automatic logic [NTYPE-1:0] f_decode(input logic [31:0] instr);
      logic [NTYPE-1:0] t;
      t = '0;
      if (instr[1:0] == 2'b11) begin
         case (instr[6:2])
            5'b00000, 5'b00011, 5'b00100,
            5'b11001, 5'b11100:  t[I_INDEX] = 1'b1;
            5'b00110:            t[I_INDEX] = (XLEN == 64);
            5'b01000:            t[S_INDEX] = 1'b1;
            5'b11000:            t[B_INDEX] = 1'b1;
            5'b11011:            t[J_INDEX] = 1'b1;
            5'b01101, 5'b00101:  t[U_INDEX] = 1'b1;
            default:             t = '0;
         endcase
      end
      return t;
   endfunction

   logic              r_id_valid;
   logic              r_skid_valid;
   logic              r_if_ready;
   logic [31:0]       r_id_instr;
   logic [XLEN-1:0]   r_id_pc;
   logic [NTYPE-1:0]  r_id_type;
   logic [31:0]       r_skid_instr;
   logic [XLEN-1:0]   r_skid_pc;
   logic [NTYPE-1:0]  r_skid_type;

   logic              w_accept;
   logic              w_drain;
   logic              w_main_open;
   logic              w_skid2main;
   logic              w_if2main;
   logic              w_if2skid;
   logic              w_main_valid_nxt;
   logic              w_skid_valid_nxt;
   logic [NTYPE-1:0]  w_if_type;

   assign w_if_type   = f_decode(bus.if_instr);
   assign w_accept    = bus.if_valid && r_if_ready;
   assign w_drain     = r_id_valid && bus.id_ready;
   assign w_main_open = !r_id_valid || w_drain;
   // Skid contents always take precedence over fetch so ordering holds;
   // if_ready is low whenever skid is full, so both never compete.
   assign w_skid2main = r_skid_valid && w_drain;
   assign w_if2main   = w_accept && w_main_open && !r_skid_valid;
   assign w_if2skid   = w_accept && !w_main_open;

   assign w_main_valid_nxt = w_skid2main || w_if2main || (r_id_valid && !w_drain);
   assign w_skid_valid_nxt = w_if2skid || (r_skid_valid && !w_drain);

   // Occupancy flags and registered ready; flush empties both entries.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_id_valid   <= 1'b0;
         r_skid_valid <= 1'b0;
         r_if_ready   <= 1'b1;
      end else if (bus.flush) begin
         r_id_valid   <= 1'b0;
         r_skid_valid <= 1'b0;
         r_if_ready   <= 1'b1;
      end else begin
         r_id_valid   <= w_main_valid_nxt;
         r_skid_valid <= w_skid_valid_nxt;
         r_if_ready   <= ~w_skid_valid_nxt;
      end
   end

   // Data registers load only on capture, keeping outputs stable under stall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_id_instr   <= RESET_INSTR;
         r_id_pc      <= RESET_PC;
         r_id_type    <= f_decode(RESET_INSTR);
         r_skid_instr <= '0;
         r_skid_pc    <= '0;
         r_skid_type  <= '0;
      end else if (!bus.flush) begin
         if (w_skid2main) begin
            r_id_instr <= r_skid_instr;
            r_id_pc    <= r_skid_pc;
            r_id_type  <= r_skid_type;
         end else if (w_if2main) begin
            r_id_instr <= bus.if_instr;
            r_id_pc    <= bus.if_pc;
            r_id_type  <= w_if_type;
         end
         if (w_if2skid) begin
            r_skid_instr <= bus.if_instr;
            r_skid_pc    <= bus.if_pc;
            r_skid_type  <= w_if_type;
         end
      end
   end

`ifdef ILL_INSTR_CHECK_EN
   logic r_id_illegal;
   logic r_skid_illegal;
   logic w_if_rtype;
   logic w_if_illegal;

   assign w_if_rtype   = (bus.if_instr[6:0] == 7'b0110011) ||
                         ((XLEN == 64) && (bus.if_instr[6:0] == 7'b0111011));
   assign w_if_illegal = (w_if_type == '0) && !w_if_rtype;

   // Illegal flag travels with its instruction through skid and main.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_id_illegal   <= 1'b0;
         r_skid_illegal <= 1'b0;
      end else if (!bus.flush) begin
         if (w_skid2main)    r_id_illegal <= r_skid_illegal;
         else if (w_if2main) r_id_illegal <= w_if_illegal;
         if (w_if2skid)      r_skid_illegal <= w_if_illegal;
      end
   end

   assign bus.id_illegal = r_id_illegal;
`else
   assign bus.id_illegal = 1'b0;
`endif

   assign bus.if_ready      = r_if_ready;
   assign bus.id_valid      = r_id_valid;
   assign bus.id_instr      = r_id_instr;
   assign bus.id_pc         = r_id_pc;
   assign bus.id_instr_type = r_id_type;
endmodule

// File: tb/tb_id_stage_reg.sv
// Directed bench for id_stage_reg: a scoreboard queue holds instructions the
// stage is expected to be holding; its front is compared every cycle.
module tb_id_stage_reg;
   localparam int unsigned XLEN = 32;
   localparam logic [4:0] T_B = 5'b00001;
   localparam logic [4:0] T_I = 5'b00010;
   localparam logic [4:0] T_J = 5'b00100;
   localparam logic [4:0] T_S = 5'b01000;
   localparam logic [4:0] T_U = 5'b10000;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [4:0]  typ;
      logic        ill;
   } exp_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   logic m_rdy;
   exp_t q[$];

   id_stage_reg_if #(.XLEN(XLEN), .NTYPE(5)) bus ();

   id_stage_reg #(
      .XLEN(XLEN),
      .RESET_INSTR(32'h0000_0013),
      .RESET_PC('0)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [4:0] exp_type(input logic [31:0] ins);
      case (ins[6:0])
         7'h03, 7'h0F, 7'h13, 7'h67, 7'h73: return T_I;
         7'h1B:         return (XLEN == 64) ? T_I : 5'b0;
         7'h23:         return T_S;
         7'h63:         return T_B;
         7'h6F:         return T_J;
         7'h37, 7'h17:  return T_U;
         default:       return 5'b0;
      endcase
   endfunction

   function automatic logic exp_ill(input logic [31:0] ins);
`ifdef ILL_INSTR_CHECK_EN
      return (exp_type(ins) == 5'b0) && (ins[6:0] != 7'h33) &&
             !((XLEN == 64) && (ins[6:0] == 7'h3B));
`else
      return 1'b0;
`endif
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic check_outputs();
      chk("if_ready", {63'd0, bus.if_ready}, {63'd0, m_rdy});
      chk("id_valid", {63'd0, bus.id_valid}, {63'd0, q.size() != 0});
      if (q.size() != 0) begin
         chk("id_instr", {32'd0, bus.id_instr}, {32'd0, q[0].instr});
         chk("id_pc",    {32'd0, bus.id_pc},    {32'd0, q[0].pc});
         chk("id_type",  {59'd0, bus.id_instr_type}, {59'd0, q[0].typ});
         chk("id_illegal", {63'd0, bus.id_illegal}, {63'd0, q[0].ill});
      end
   endtask

   // One clock cycle: drive inputs, compare against model, advance model.
   task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic idr, input logic fl);
      logic accept;
      logic drain;
      exp_t e;
      bus.if_valid = v;
      bus.if_instr = ins;
      bus.if_pc    = pc;
      bus.id_ready = idr;
      bus.flush    = fl;
      #3;
      check_outputs();
      accept = v && m_rdy;
      drain  = (q.size() != 0) && idr;
      if (fl) begin
         q.delete();
         m_rdy = 1'b1;
      end else begin
         if (drain) void'(q.pop_front());
         if (accept) begin
            e.instr = ins;
            e.pc    = pc;
            e.typ   = exp_type(ins);
            e.ill   = exp_ill(ins);
            q.push_back(e);
         end
         m_rdy = (q.size() < 2);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      m_rdy  = 1'b1;
      rst    = 1'b1;
      bus.if_valid = 1'b0;
      bus.if_instr = '0;
      bus.if_pc    = '0;
      bus.id_ready = 1'b0;
      bus.flush    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // reset state
      chk("rst_id_valid", {63'd0, bus.id_valid}, 64'd0);
      chk("rst_if_ready", {63'd0, bus.if_ready}, 64'd1);
      chk("rst_id_instr", {32'd0, bus.id_instr}, 64'h13);
      chk("rst_id_pc",    {32'd0, bus.id_pc},    64'd0);
      chk("rst_id_type",  {59'd0, bus.id_instr_type}, {59'd0, T_I});
      chk("rst_id_illegal", {63'd0, bus.id_illegal}, 64'd0);

      // addi, then back-to-back B/J/S/U with downstream always ready
      step(1'b1, 32'hFFF0_0093, 32'h100, 1'b1, 1'b0);
      step(1'b1, 32'h0000_0063, 32'h104, 1'b1, 1'b0);
      step(1'b1, 32'h0000_006F, 32'h108, 1'b1, 1'b0);
      step(1'b1, 32'h0000_0023, 32'h10C, 1'b1, 1'b0);
      step(1'b1, 32'h0000_0037, 32'h110, 1'b1, 1'b0);
      step(1'b0, 32'h0,         32'h0,   1'b1, 1'b0);
      step(1'b0, 32'h0,         32'h0,   1'b1, 1'b0);

      // stall: 1st held in main, 2nd in skid, 3rd refused until space
      step(1'b1, 32'h0010_0113, 32'h200, 1'b0, 1'b0);
      step(1'b1, 32'h0020_0193, 32'h204, 1'b0, 1'b0);
      step(1'b1, 32'h0030_0213, 32'h208, 1'b0, 1'b0);
      chk("stall_if_ready_low", {63'd0, bus.if_ready}, 64'd0);
      step(1'b1, 32'h0030_0213, 32'h208, 1'b1, 1'b0);
      step(1'b1, 32'h0030_0213, 32'h208, 1'b1, 1'b0);
      step(1'b0, 32'h0,         32'h0,   1'b1, 1'b0);
      step(1'b0, 32'h0,         32'h0,   1'b1, 1'b0);
      chk("stall_drained", {63'd0, bus.id_valid}, 64'd0);

      // flush with main and skid full and a new instruction offered
      step(1'b1, 32'h0040_0293, 32'h300, 1'b0, 1'b0);
      step(1'b1, 32'h0050_0313, 32'h304, 1'b0, 1'b0);
      step(1'b1, 32'h0060_0393, 32'h308, 1'b1, 1'b1);
      chk("flush_id_valid", {63'd0, bus.id_valid}, 64'd0);
      chk("flush_if_ready", {63'd0, bus.if_ready}, 64'd1);
      step(1'b1, 32'h0070_0413, 32'h30C, 1'b1, 1'b0);
      step(1'b0, 32'h0,         32'h0,   1'b1, 1'b0);

      // R-type, unknown opcode, RV64-only opcode, non-32-bit encoding
      step(1'b1, 32'h0000_0033, 32'h400, 1'b1, 1'b0);
      step(1'b1, 32'h0000_007F, 32'h404, 1'b1, 1'b0);
      step(1'b1, 32'h0000_001B, 32'h408, 1'b1, 1'b0);
      step(1'b1, 32'h0000_0010, 32'h40C, 1'b1, 1'b0);
      step(1'b1, 32'h0000_0017, 32'h410, 1'b1, 1'b0);
      step(1'b0, 32'h0,         32'h0,   1'b1, 1'b0);
`ifndef ILL_INSTR_CHECK_EN
      chk("illegal_tied_low", {63'd0, bus.id_illegal}, 64'd0);
`endif

      // asynchronous reset between edges while holding a valid instruction
      step(1'b1, 32'h0080_0493, 32'h500, 1'b0, 1'b0);
      chk("pre_rst_valid", {63'd0, bus.id_valid}, 64'd1);
      bus.if_valid = 1'b0;
      #1;
      rst = 1'b1;
      #1;
      chk("async_rst_valid", {63'd0, bus.id_valid}, 64'd0);
      chk("async_rst_instr", {32'd0, bus.id_instr}, 64'h13);
      chk("async_rst_type",  {59'd0, bus.id_instr_type}, {59'd0, T_I});
      chk("async_rst_ready", {63'd0, bus.if_ready}, 64'd1);
      rst = 1'b0;
      q.delete();
      m_rdy = 1'b1;
      @(posedge clk);
      #1;
      step(1'b1, 32'h0090_0513, 32'h600, 1'b1, 1'b0);
      step(1'b0, 32'h0,         32'h0,   1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
